ped_crossing_controller: RTL and testbench
==========================================

// Module: ped_crossing_controller
// PURPOSE
//   Downstream consumer of the traffic light controller's one-hot light bus (100=RED, 010=GREEN, 001=YELLOW).
//   Latches pedestrian button requests and grants a WALK window at the start of a red phase.
//   Drives WALK / flashing DON'T WALK signal heads, a countdown display and a light-bus fault flag.
// PARAMETERS
//   WALK_CYCLES   3   clocks with walk=1 (>=1)
//   FLASH_CYCLES  2   clocks of flashing dont_walk after WALK (>=1)
//   CNT_W         4   countdown width; WALK_CYCLES+FLASH_CYCLES <= 2**CNT_W-1
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   light      in   3      one-hot light code from the upstream controller
//   ped_btn    in   1      raw pedestrian push button, asynchronous to clk
//   walk       out  1      WALK lamp
//   dont_walk  out  1      DON'T WALK lamp (steady or flashing)
//   ped_wait   out  1      request pending ("WAIT" indicator)
//   countdown  out  CNT_W  clocks remaining in WALK+FLASH window, 0 otherwise
//   fault      out  1      light code was not one of 100/010/001 last cycle
// BEHAVIOUR
//   - All outputs registered. Reset: walk=0, dont_walk=1, ped_wait=0, countdown=0, fault=0, state=IDLE,
//     sync flops=0, light_q=3'b100 (a red held through reset is NOT a red entry).
//   - ped_btn passes a 2-flop synchronizer plus a rising-edge detector; ped_wait rises on the 3rd clock edge
//     after the first edge that samples ped_btn=1. Holding the button produces one request only.
//   - red_entry = (light==100) && (light_q!=100); light_q <= light every cycle.
//   - FSM states: IDLE, WALK, FLASH.
//     IDLE: walk=0, dont_walk=1, countdown=0. red_entry && ped_wait -> WALK.
//     WALK: walk=1, dont_walk=0; lasts exactly WALK_CYCLES clocks -> FLASH.
//     FLASH: walk=0; dont_walk=1,0,1,... starting at 1 on the first FLASH cycle; lasts FLASH_CYCLES -> IDLE.
//   - countdown: first WALK cycle shows WALK_CYCLES+FLASH_CYCLES, decrements by 1 each clock,
//     last FLASH cycle shows 1, IDLE shows 0. No wrap possible given the parameter constraint.
//   - ped_wait next = (ped_wait & ~grant) | btn_rise; a press on the grant cycle leaves ped_wait=1 for the next red.
//     Presses during WALK/FLASH set ped_wait for the next red entry.
//   - Safety abort: in WALK or FLASH, light!=100 -> IDLE on the next edge (walk=0, dont_walk=1, countdown=0);
//     ped_wait unchanged.
//   - fault <= (light not in {100,010,001}); not sticky. An invalid code is treated as not-red (abort applies;
//     no red_entry possible).
//   - red_entry without ped_wait: no grant, remains IDLE until a later red entry.
//   - Asynchronous rst mid-window: all outputs revert to reset values immediately; pending request dropped.
// CONFIGURATION
//   PED_CHIRP_EN defined: extra output port chirp (1 bit); toggles every clock while state==WALK
//     (first WALK cycle =1) and is 0 in all other states and at reset.
//   PED_CHIRP_EN undefined: chirp port and its logic absent; all other behaviour identical.
// STRUCTURE
//   Package ped_pkg: state enum {IDLE,WALK,FLASH}; light constants LIGHT_RED=3'b100, LIGHT_GREEN=3'b010,
//     LIGHT_YELLOW=3'b001 (shared with the traffic light controller).
//   Sub-module ped_btn_sync: 2-flop synchronizer + rising-edge pulse (clk, rst, btn_in -> btn_rise).
//   Top: light_q register, FSM, window counter, output registers, optional chirp.
// TESTING (defaults W=3, F=2)
//   1 Reset: assert rst with light=100, ped_btn=1 -> walk=0, dont_walk=1, ped_wait=0, countdown=0, fault=0
//     immediately; release with light held 100 -> no WALK.
//   2 Press during light=010, then light 010->100 -> ped_wait=1 before red; after red entry walk=1 for 3 clocks
//     (countdown 5,4,3), ped_wait=0; then dont_walk 1,0 (countdown 2,1); then IDLE, dont_walk=1, countdown=0.
//   3 light 001->100 with no press -> stays IDLE, walk never 1, countdown=0.
//   4 Grant, then light->010 on 2nd WALK cycle -> next edge walk=0, dont_walk=1, countdown=0, state IDLE.
//   5 light=3'b110 for one cycle -> fault=1 for exactly one cycle; no grant even if ped_wait=1.
//   6 Button held 20 clocks across a grant -> exactly one grant; assert rst mid-FLASH -> outputs at reset
//     values at once. With PED_CHIRP_EN: chirp 1,0,1 during WALK, 0 elsewhere.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types for the pedestrian crossing controller: FSM states and the one-hot light codes
// also used by the upstream traffic light controller.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2
    } ped_state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    function automatic logic light_valid(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_GREEN) || (code == LIGHT_YELLOW);
    endfunction

endpackage

// File: rtl/ped_crossing_controller_if.sv
// Light bus in, signal heads out; the chirp lamp exists only when PED_CHIRP_EN is defined.
// No handshake: the light bus is sampled every clock and outputs are level signals.
interface ped_crossing_controller_if #(
    parameter int CNT_W = 4
);
    logic [2:0]       light;
    logic             ped_btn;
    logic             walk;
    logic             dont_walk;
    logic             ped_wait;
    logic [CNT_W-1:0] countdown;
    logic             fault;

`ifdef PED_CHIRP_EN
    logic             chirp;

    modport master (
        output light, ped_btn,
        input  walk, dont_walk, ped_wait, countdown, fault, chirp
    );

    modport slave (
        input  light, ped_btn,
        output walk, dont_walk, ped_wait, countdown, fault, chirp
    );
`else
    modport master (
        output light, ped_btn,
        input  walk, dont_walk, ped_wait, countdown, fault
    );

    modport slave (
        input  light, ped_btn,
        output walk, dont_walk, ped_wait, countdown, fault
    );
`endif

endinterface

// File: rtl/ped_btn_sync.sv
// Two-flop synchronizer for the raw push button plus a registered one-clock rising-edge pulse.
// Latency: pulse appears two clocks after the first edge that samples the button high; no backpressure.
module ped_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_rise
);

    logic sync_a;
    logic sync_b;
    logic sync_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            sync_b_q <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            sync_a   <= btn_in;
            sync_b   <= sync_a;
            sync_b_q <= sync_b;
            btn_rise <= sync_b & ~sync_b_q;
        end
    end

endmodule

// File: rtl/ped_crossing_controller.sv
// Grants a WALK + flashing DON'T WALK window at red entry when a request is pending; optional chirp under PED_CHIRP_EN.
// All outputs registered (one clock after the deciding light sample); no backpressure, abort on any non-red light.
module ped_crossing_controller
    import ped_pkg::*;
#(
    parameter int WALK_CYCLES  = 3,
    parameter int FLASH_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input logic                     clk,
    input logic                     rst,
    ped_crossing_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] WINDOW    = CNT_W'(WALK_CYCLES + FLASH_CYCLES);
    localparam logic [CNT_W-1:0] LAST_WALK = CNT_W'(FLASH_CYCLES + 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    ped_state_t       state, state_d;
    logic [2:0]       light_q;
    logic             btn_rise;
    logic             is_red;
    logic             red_entry;
    logic             grant;

    logic             walk_r, walk_d;
    logic             dont_walk_r, dont_walk_d;
    logic             ped_wait_r, ped_wait_d;
    logic [CNT_W-1:0] countdown_r, countdown_d;
    logic             fault_r, fault_d;
`ifdef PED_CHIRP_EN
    logic             chirp_r, chirp_d;
`endif

    ped_btn_sync u_btn_sync (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (bus.ped_btn),
        .btn_rise (btn_rise)
    );

    // Invalid codes are never red, so they abort a window and cannot start one.
    assign is_red    = (bus.light == LIGHT_RED);
    assign red_entry = is_red && (light_q != LIGHT_RED);

    always_comb begin
        state_d     = state;
        grant       = 1'b0;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        countdown_d = '0;
`ifdef PED_CHIRP_EN
        chirp_d     = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (red_entry && ped_wait_r) begin
                    grant   = 1'b1;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (!is_red) begin
                    state_d = IDLE;
                end else if (countdown_r == LAST_WALK) begin
                    state_d = FLASH;
                end
            end
            FLASH: begin
                if (!is_red || (countdown_r == ONE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they line up with the state register.
        case (state_d)
            WALK: begin
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
                countdown_d = grant ? WINDOW : (countdown_r - ONE);
`ifdef PED_CHIRP_EN
                chirp_d     = (state == WALK) ? ~chirp_r : 1'b1;
`endif
            end
            FLASH: begin
                dont_walk_d = (state == FLASH) ? ~dont_walk_r : 1'b1;
                countdown_d = countdown_r - ONE;
            end
            default: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
                countdown_d = '0;
            end
        endcase

        // A press coinciding with the grant survives for the next red.
        ped_wait_d = (ped_wait_r & ~grant) | btn_rise;
        fault_d    = ~light_valid(bus.light);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            light_q     <= LIGHT_RED;
            walk_r      <= 1'b0;
            dont_walk_r <= 1'b1;
            ped_wait_r  <= 1'b0;
            countdown_r <= '0;
            fault_r     <= 1'b0;
        end else begin
            state       <= state_d;
            light_q     <= bus.light;
            walk_r      <= walk_d;
            dont_walk_r <= dont_walk_d;
            ped_wait_r  <= ped_wait_d;
            countdown_r <= countdown_d;
            fault_r     <= fault_d;
        end
    end

`ifdef PED_CHIRP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chirp_r <= 1'b0;
        end else begin
            chirp_r <= chirp_d;
        end
    end

    assign bus.chirp = chirp_r;
`endif

    assign bus.walk      = walk_r;
    assign bus.dont_walk = dont_walk_r;
    assign bus.ped_wait  = ped_wait_r;
    assign bus.countdown = countdown_r;
    assign bus.fault     = fault_r;

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Directed bench for ped_crossing_controller with WALK_CYCLES=3, FLASH_CYCLES=2, CNT_W=4.
module tb_ped_crossing_controller;
    import ped_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ped_crossing_controller_if #(.CNT_W(4)) bus ();

    ped_crossing_controller #(
        .WALK_CYCLES  (3),
        .FLASH_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_heads(input string tag, input logic w, input logic dw, input logic [3:0] cd);
        chk({tag, ".walk"}, 32'(bus.walk), 32'(w));
        chk({tag, ".dont_walk"}, 32'(bus.dont_walk), 32'(dw));
        chk({tag, ".countdown"}, 32'(bus.countdown), 32'(cd));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_heads(tag, 1'b0, 1'b1, 4'd0);
        chk({tag, ".ped_wait"}, 32'(bus.ped_wait), 32'd0);
        chk({tag, ".fault"}, 32'(bus.fault), 32'd0);
`ifdef PED_CHIRP_EN
        chk({tag, ".chirp"}, 32'(bus.chirp), 32'd0);
`endif
    endtask

    // One-clock press: sampled on edge E0, request visible after E3.
    task automatic press_and_wait(input string tag);
        bus.ped_btn = 1'b1;
        step(1);
        bus.ped_btn = 1'b0;
        step(3);
        chk({tag, ".ped_wait"}, 32'(bus.ped_wait), 32'd1);
    endtask

    int   exp_cd[6] = '{5, 4, 3, 2, 1, 0};
    logic exp_w[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_dw[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef PED_CHIRP_EN
    logic exp_ch[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

    int   grants;
    logic prev_walk;

    initial begin
        // 1: reset with red held and button pressed
        rst         = 1'b1;
        bus.light   = LIGHT_RED;
        bus.ped_btn = 1'b1;
        step(3);
        chk_reset_vals("t1.reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("t1.no_walk", 32'(bus.walk), 32'd0);
        end
        chk("t1.held_req", 32'(bus.ped_wait), 32'd1);
        bus.ped_btn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t1.async_clr", 32'(bus.ped_wait), 32'd0);
        step(1);
        rst = 1'b0;

        // 2: press during green, full window at red entry
        bus.light = LIGHT_GREEN;
        step(2);
        bus.ped_btn = 1'b1;
        step(1); chk("t2.wait_e0", 32'(bus.ped_wait), 32'd0);
        step(1); chk("t2.wait_e1", 32'(bus.ped_wait), 32'd0);
        step(1); chk("t2.wait_e2", 32'(bus.ped_wait), 32'd0);
        step(1); chk("t2.wait_e3", 32'(bus.ped_wait), 32'd1);
        bus.ped_btn = 1'b0;
        step(1);
        bus.light = LIGHT_RED;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk_heads($sformatf("t2.win%0d", k), exp_w[k], exp_dw[k], 4'(exp_cd[k]));
`ifdef PED_CHIRP_EN
            chk($sformatf("t2.chirp%0d", k), 32'(bus.chirp), 32'(exp_ch[k]));
`endif
            if (k == 0) chk("t2.wait_clr", 32'(bus.ped_wait), 32'd0);
        end

        // 3: red entry with no request
        bus.light = LIGHT_YELLOW;
        step(1);
        bus.light = LIGHT_RED;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_heads("t3.idle", 1'b0, 1'b1, 4'd0);
        end

        // 4: abort on second WALK cycle
        bus.light = LIGHT_GREEN;
        step(1);
        press_and_wait("t4");
        bus.light = LIGHT_RED;
        step(1); chk_heads("t4.w1", 1'b1, 1'b0, 4'd5);
        step(1); chk_heads("t4.w2", 1'b1, 1'b0, 4'd4);
        bus.light = LIGHT_GREEN;
        step(1); chk_heads("t4.abort", 1'b0, 1'b1, 4'd0);
        step(1); chk_heads("t4.idle", 1'b0, 1'b1, 4'd0);
        bus.light = LIGHT_RED;
        step(1); chk("t4.no_regrant", 32'(bus.walk), 32'd0);

        // 5: single-cycle invalid code
        bus.light = LIGHT_GREEN;
        step(1);
        press_and_wait("t5");
        bus.light = 3'b110;
        step(1);
        chk("t5.fault_set", 32'(bus.fault), 32'd1);
        chk("t5.no_grant", 32'(bus.walk), 32'd0);
        bus.light = LIGHT_GREEN;
        step(1);
        chk("t5.fault_clr", 32'(bus.fault), 32'd0);
        chk("t5.walk", 32'(bus.walk), 32'd0);
        chk("t5.wait_kept", 32'(bus.ped_wait), 32'd1);
        bus.light = LIGHT_RED;
        step(1); chk_heads("t5.grant", 1'b1, 1'b0, 4'd5);
        step(5); chk_heads("t5.done", 1'b0, 1'b1, 4'd0);

        // 6a: button held 20 clocks across a grant
        bus.light = LIGHT_GREEN;
        step(1);
        grants      = 0;
        prev_walk   = bus.walk;
        bus.ped_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) bus.light = LIGHT_RED;
            step(1);
            if (bus.walk && !prev_walk) grants++;
            prev_walk = bus.walk;
        end
        bus.ped_btn = 1'b0;
        chk("t6.one_grant", 32'(grants), 32'd1);
        chk("t6.wait_clr", 32'(bus.ped_wait), 32'd0);
        bus.light = LIGHT_GREEN;
        step(1);
        bus.light = LIGHT_RED;
        step(1);
        chk("t6.no_second", 32'(bus.walk), 32'd0);

        // 6b: async reset in the last FLASH cycle with a request pending
        bus.light = LIGHT_GREEN;
        step(1);
        press_and_wait("t6b");
        bus.light = LIGHT_RED;
        step(1);
        chk_heads("t6b.grant", 1'b1, 1'b0, 4'd5);
        bus.ped_btn = 1'b1;
        step(1);
        bus.ped_btn = 1'b0;
        step(3);
        chk_heads("t6b.flash2", 1'b0, 1'b0, 4'd1);
        chk("t6b.wait_pend", 32'(bus.ped_wait), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("t6b.rst");
        step(1);
        rst = 1'b0;
        step(3);
        chk("t6b.after", 32'(bus.walk), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
